fg_config_writer: RTL and testbench

Host-side driver for the function generator's parallel configuration bus: accepts register write requests over a valid/ready handshake and sequences the address, data and enable lines with the setup, strobe and hold windows the receiving 2-stage enable synchronizer needs. Supports single-register writes and an 8-register burst that loads a full 64-bit configuration word. It sits between a controller (test harness, FPGA soft core, companion chip) and the address/data/enable pins of the function generator top.

---
 rtl/fg_cfg_pkg.sv | 32 +++
 rtl/fg_cfgwr_phase_timer.sv | 28 ++
 rtl/fg_config_writer.sv | 180 ++++++++++++++++++
 tb/tb_fg_config_writer.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fg_cfg_pkg.sv
// Shared types and constants for the function generator config writer.
// Holds the FSM state type, register geometry and phase-length minimums.
package fg_cfg_pkg;

  localparam int CR_COUNT         = 8;
  localparam int CR_BITWIDTH      = 8;
  localparam int CR_ADDR_BITWIDTH = 3;
  localparam int SYNC_STAGES      = 2;

  localparam int MIN_SETUP_CYCLES  = 1;
  localparam int MIN_STROBE_CYCLES = SYNC_STAGES + 1;
  localparam int MIN_HOLD_CYCLES   = SYNC_STAGES;

  localparam int TIMER_W   = 8;
  localparam int MAX_PHASE = 2 ** TIMER_W;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETUP,
    ST_STROBE,
    ST_HOLD
  } cfgwr_state_t;

  // CR0 lives in the top byte of the burst word.
  function automatic logic [CR_BITWIDTH-1:0] burst_byte(
    input logic [CR_COUNT*CR_BITWIDTH-1:0] word,
    input logic [CR_ADDR_BITWIDTH-1:0]     idx
  );
    return word[{~idx, 3'b000} +: CR_BITWIDTH];
  endfunction

endpackage

// File: rtl/fg_cfgwr_phase_timer.sv
// Loadable down-counter with zero flag.
// One instance times every bus phase; reloaded on each phase entry.
module fg_cfgwr_phase_timer
  import fg_cfg_pkg::*;
(
  input  logic               clk_i,
  input  logic               rstn_i,
  input  logic               load,
  input  logic [TIMER_W-1:0] load_value,
  output logic               zero
);

  logic [TIMER_W-1:0] cnt;

  // Count down to zero, reload on request.
  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_value;
    end else if (cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/fg_config_writer.sv
// Config bus writer: sequences addr/data/enable with setup, strobe, hold.
// Optional register mirror on shadow_o when FG_CFGWR_SHADOW_EN is defined.
module fg_config_writer
  import fg_cfg_pkg::*;
#(
  parameter int SETUP_CYCLES  = 2,
  parameter int STROBE_CYCLES = 4,
  parameter int HOLD_CYCLES   = 2
)(
  input  logic                        clk_i,
  input  logic                        rstn_i,
  input  logic                        req_valid_i,
  output logic                        req_ready_o,
  input  logic [CR_ADDR_BITWIDTH-1:0] req_addr_i,
  input  logic [CR_BITWIDTH-1:0]      req_data_i,
  input  logic                        burst_i,
  input  logic [63:0]                 burst_data_i,
  output logic [CR_BITWIDTH-1:0]      bus_data_o,
  output logic [CR_ADDR_BITWIDTH-1:0] bus_addr_o,
  output logic                        bus_en_o,
  output logic                        busy_o,
`ifdef FG_CFGWR_SHADOW_EN
  output logic [63:0]                 shadow_o,
`endif
  output logic                        done_o
);

  if (SETUP_CYCLES < MIN_SETUP_CYCLES ||
      SETUP_CYCLES > MAX_PHASE) begin : g_bad_setup
    $error("fg_config_writer: SETUP_CYCLES out of range");
  end
  if (STROBE_CYCLES < MIN_STROBE_CYCLES ||
      STROBE_CYCLES > MAX_PHASE) begin : g_bad_strobe
    $error("fg_config_writer: STROBE_CYCLES out of range");
  end
  if (HOLD_CYCLES < MIN_HOLD_CYCLES ||
      HOLD_CYCLES > MAX_PHASE) begin : g_bad_hold
    $error("fg_config_writer: HOLD_CYCLES out of range");
  end

  localparam logic [TIMER_W-1:0] SETUP_LD  = TIMER_W'(SETUP_CYCLES - 1);
  localparam logic [TIMER_W-1:0] STROBE_LD = TIMER_W'(STROBE_CYCLES - 1);
  localparam logic [TIMER_W-1:0] HOLD_LD   = TIMER_W'(HOLD_CYCLES - 1);

  cfgwr_state_t                state;
  logic [63:0]                 word_q;
  logic                        burst_q;
  logic [CR_ADDR_BITWIDTH-1:0] k;
  logic                        accept;
  logic                        last;
  logic                        t_load;
  logic [TIMER_W-1:0]          t_value;
  logic                        t_zero;

  assign accept = req_valid_i & req_ready_o;
  assign last   = ~burst_q | (k == CR_ADDR_BITWIDTH'(CR_COUNT - 1));

  fg_cfgwr_phase_timer u_timer (
    .clk_i      (clk_i),
    .rstn_i     (rstn_i),
    .load       (t_load),
    .load_value (t_value),
    .zero       (t_zero)
  );

  // Reload the phase timer on every state entry.
  always_comb begin
    t_load  = 1'b0;
    t_value = '0;
    unique case (state)
      ST_IDLE: begin
        if (accept) begin
          t_load  = 1'b1;
          t_value = SETUP_LD;
        end
      end
      ST_SETUP: begin
        if (t_zero) begin
          t_load  = 1'b1;
          t_value = STROBE_LD;
        end
      end
      ST_STROBE: begin
        if (t_zero) begin
          t_load  = 1'b1;
          t_value = HOLD_LD;
        end
      end
      ST_HOLD: begin
        if (t_zero && !last) begin
          t_load  = 1'b1;
          t_value = SETUP_LD;
        end
      end
      default: ;
    endcase
  end

  // Transaction FSM with registered bus and handshake outputs.
  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      state       <= ST_IDLE;
      word_q      <= '0;
      burst_q     <= 1'b0;
      k           <= '0;
      req_ready_o <= 1'b0;
      busy_o      <= 1'b0;
      done_o      <= 1'b0;
      bus_en_o    <= 1'b0;
      bus_data_o  <= '0;
      bus_addr_o  <= '0;
    end else begin
      done_o <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          req_ready_o <= 1'b1;
          if (accept) begin
            state       <= ST_SETUP;
            req_ready_o <= 1'b0;
            busy_o      <= 1'b1;
            word_q      <= burst_data_i;
            burst_q     <= burst_i;
            k           <= '0;
            if (burst_i) begin
              bus_addr_o <= '0;
              bus_data_o <= burst_byte(burst_data_i, '0);
            end else begin
              bus_addr_o <= req_addr_i;
              bus_data_o <= req_data_i;
            end
          end
        end
        ST_SETUP: begin
          if (t_zero) begin
            state    <= ST_STROBE;
            bus_en_o <= 1'b1;
          end
        end
        ST_STROBE: begin
          if (t_zero) begin
            state    <= ST_HOLD;
            bus_en_o <= 1'b0;
          end
        end
        ST_HOLD: begin
          if (t_zero) begin
            if (last) begin
              state       <= ST_IDLE;
              done_o      <= 1'b1;
              req_ready_o <= 1'b1;
              busy_o      <= 1'b0;
            end else begin
              state      <= ST_SETUP;
              k          <= k + 1'b1;
              bus_addr_o <= k + 1'b1;
              bus_data_o <= burst_byte(word_q, k + 1'b1);
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef FG_CFGWR_SHADOW_EN
  logic [63:0] shadow_q;

  // Mirror the byte being written on its last strobe cycle.
  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      shadow_q <= '0;
    end else if (state == ST_STROBE && t_zero) begin
      shadow_q[{~bus_addr_o, 3'b000} +: CR_BITWIDTH] <= bus_data_o;
    end
  end

  assign shadow_o = shadow_q;
`endif

endmodule

// File: tb/tb_fg_config_writer.sv
// Scoreboard bench for fg_config_writer with default phase lengths.
// Build with FG_CFGWR_SHADOW_EN to also check the register mirror.
module tb_fg_config_writer;

  localparam int S = 2;
  localparam int T = 4;
  localparam int H = 2;
  localparam int P = S + T + H;

  logic        clk = 1'b0;
  logic        rstn;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  req_addr;
  logic [7:0]  req_data;
  logic        burst;
  logic [63:0] burst_data;
  logic [7:0]  bus_data;
  logic [2:0]  bus_addr;
  logic        bus_en;
  logic        busy;
  logic        done;
`ifdef FG_CFGWR_SHADOW_EN
  logic [63:0] shadow;
`endif

  fg_config_writer #(
    .SETUP_CYCLES  (S),
    .STROBE_CYCLES (T),
    .HOLD_CYCLES   (H)
  ) dut (
    .clk_i        (clk),
    .rstn_i       (rstn),
    .req_valid_i  (req_valid),
    .req_ready_o  (req_ready),
    .req_addr_i   (req_addr),
    .req_data_i   (req_data),
    .burst_i      (burst),
    .burst_data_i (burst_data),
    .bus_data_o   (bus_data),
    .bus_addr_o   (bus_addr),
    .bus_en_o     (bus_en),
    .busy_o       (busy),
`ifdef FG_CFGWR_SHADOW_EN
    .shadow_o     (shadow),
`endif
    .done_o       (done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [2:0] a;
    logic [7:0] d;
    int         t;
  } wr_t;

  typedef struct {
    int          t;
    logic [63:0] sh;
  } dn_t;

  wr_t        wq[$];
  dn_t        dq[$];
  logic [7:0] model [8];
  int         n_cmp = 0;
  int         n_bad = 0;
  logic       acc;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic logic [63:0] pack_model();
    logic [63:0] w;
    for (int i = 0; i < 8; i++) w[63-8*i -: 8] = model[i];
    return w;
  endfunction

  // Expected bus writes and completion for a request accepted at edge n.
  task automatic model_accept(input int n, input logic [2:0] a,
                              input logic [7:0] d, input logic b,
                              input logic [63:0] w);
    wr_t e;
    dn_t f;
    if (b) begin
      for (int i = 0; i < 8; i++) begin
        e.a = 3'(i);
        e.d = w[63-8*i -: 8];
        e.t = n + i * P + S;
        model[i] = e.d;
        wq.push_back(e);
      end
      f.t = n + 8 * P;
    end else begin
      e.a = a;
      e.d = d;
      e.t = n + S;
      model[a] = d;
      wq.push_back(e);
      f.t = n + P;
    end
    f.sh = pack_model();
    dq.push_back(f);
  endtask

  task automatic drive(input logic v, input logic [2:0] a,
                       input logic [7:0] d, input logic b,
                       input logic [63:0] w);
    @(negedge clk);
    req_valid  = v;
    req_addr   = a;
    req_data   = d;
    burst      = b;
    burst_data = w;
    acc        = v && req_ready && rstn;
    if (acc) model_accept(cyc + 1, a, d, b, w);
  endtask

  task automatic send(input logic [2:0] a, input logic [7:0] d,
                      input logic b, input logic [63:0] w);
    acc = 1'b0;
    for (int i = 0; i < 200 && !acc; i++) drive(1'b1, a, d, b, w);
    if (!acc) chk("send_timeout", 0, 1);
    drive(1'b0, 3'd0, 8'd0, 1'b0, 64'd0);
  endtask

  task automatic drain();
    for (int i = 0; i < 800 && (wq.size() != 0 || dq.size() != 0); i++)
      drive(1'b0, 3'd0, 8'd0, 1'b0, 64'd0);
    chk("drain_writes", 64'(wq.size()), 0);
    chk("drain_dones", 64'(dq.size()), 0);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_ready"}, req_ready, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_en"}, bus_en, 0);
    chk({tag, "_data"}, bus_data, 0);
    chk({tag, "_addr"}, bus_addr, 0);
`ifdef FG_CFGWR_SHADOW_EN
    chk({tag, "_shadow"}, shadow, 0);
`endif
  endtask

  // Monitor: match strobes and done pulses against the scoreboard.
  logic prev_en = 1'b0;
  int   slen    = 0;
  always @(negedge clk) begin
    wr_t e;
    dn_t f;
    if (!rstn) begin
      prev_en = 1'b0;
      slen    = 0;
    end else begin
      if (bus_en && !prev_en) begin
        slen = 1;
        if (wq.size() == 0) begin
          chk("strobe_unexpected", 1, 0);
        end else begin
          e = wq.pop_front();
          chk("strobe_addr", bus_addr, e.a);
          chk("strobe_data", bus_data, e.d);
          chk("strobe_cycle", 64'(cyc), 64'(e.t));
          chk("strobe_busy", busy, 1);
          chk("strobe_ready", req_ready, 0);
        end
      end else if (bus_en) begin
        slen++;
      end else if (prev_en) begin
        chk("strobe_len", 64'(slen), 64'(T));
      end
      if (done) begin
        if (dq.size() == 0) begin
          chk("done_unexpected", 1, 0);
        end else begin
          f = dq.pop_front();
          chk("done_cycle", 64'(cyc), 64'(f.t));
          chk("done_ready", req_ready, 1);
          chk("done_busy", busy, 0);
`ifdef FG_CFGWR_SHADOW_EN
          chk("done_shadow", shadow, f.sh);
`endif
        end
      end
      prev_en = bus_en;
    end
  end

  initial begin
    logic        v;
    logic        b;
    logic [63:0] w;
    int          i;
    rstn       = 1'b0;
    req_valid  = 1'b0;
    req_addr   = '0;
    req_data   = '0;
    burst      = 1'b0;
    burst_data = '0;
    for (int j = 0; j < 8; j++) model[j] = 8'h00;

    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rstn = 1'b1;
    @(negedge clk);
    chk("ready_after_reset", req_ready, 1);
    chk("busy_after_reset", busy, 0);

    send(3'd5, 8'hA7, 1'b0, 64'd0);
    chk("single_bus_addr", bus_addr, 5);
    chk("single_bus_data", bus_data, 8'hA7);
    drain();

    send(3'd0, 8'h00, 1'b1, 64'h0123_4567_89AB_CDEF);
    drain();
`ifdef FG_CFGWR_SHADOW_EN
    chk("burst_shadow", shadow, 64'h0123_4567_89AB_CDEF);
`endif

    for (int j = 0; j < 40; j++)
      drive(1'b1, 3'($urandom_range(0, 7)), 8'($urandom),
            1'b0, {$urandom, $urandom});
    drain();

    for (int j = 0; j < 600; j++) begin
      v = ($urandom_range(0, 3) != 0);
      b = ($urandom_range(0, 4) == 0);
      w = {$urandom, $urandom};
      drive(v, 3'($urandom_range(0, 7)), 8'($urandom), b, w);
    end
    drive(1'b0, 3'd0, 8'd0, 1'b0, 64'd0);
    drain();

    send(3'd0, 8'h00, 1'b1, {$urandom, $urandom});
    for (i = 0; i < 300 && !(bus_en && bus_addr == 3'd3); i++)
      @(negedge clk);
    chk("reach_byte3_strobe", (bus_en && bus_addr == 3'd3), 1);
    rstn = 1'b0;
    @(negedge clk);
    check_all_zero("midreset");
    wq.delete();
    dq.delete();
    for (int j = 0; j < 8; j++) model[j] = 8'h00;
    rstn = 1'b1;
    @(negedge clk);
    chk("ready_after_midreset", req_ready, 1);
    chk("en_after_midreset", bus_en, 0);

    send(3'd2, 8'h5C, 1'b0, 64'd0);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
